// File: rtl/phoneme_playback_engine_if.sv
// Handshake and ROM bus between the speech bus controller / ROMs and the phoneme playback engine.
// The engine connects through the slave modport; the environment connects through master.
interface phoneme_playback_engine_if #(
  parameter int ADDR_W = 16
);
  logic              start_phoneme_output;
  logic [7:0]        phoneme_sel;
  logic              phoneme_speech_busy;
  logic              phoneme_done;
  logic [7:0]        index_rom_addr;
  logic [31:0]       index_rom_data;
  logic [ADDR_W-1:0] sample_rom_addr;
  logic [7:0]        sample_rom_data;
  logic [7:0]        audio_sample;
  logic              audio_valid;

  modport master (
    output start_phoneme_output, phoneme_sel, index_rom_data, sample_rom_data,
    input  phoneme_speech_busy, phoneme_done, index_rom_addr, sample_rom_addr,
           audio_sample, audio_valid
  );

  modport slave (
    input  start_phoneme_output, phoneme_sel, index_rom_data, sample_rom_data,
    output phoneme_speech_busy, phoneme_done, index_rom_addr, sample_rom_addr,
           audio_sample, audio_valid
  );
endinterface

// File: rtl/phoneme_playback_engine.sv
// Phoneme playback engine: index ROM lookup, then paced PCM streaming from the sample ROM.
// Optional PHONEME_GAP_EN appends GAP_TICKS silent (8'h80) samples after each phoneme.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for start; index address loaded on accept if code valid
// IDX_REQ   | index ROM address stable; invalid codes skip to DONE
// IDX_LOAD  | capture start pointer and length from index ROM
// FETCH     | sample ROM address stable for the read
// LATCH     | capture sample ROM data into hold register
// WAIT_TICK | emit held sample on the next divider tick
// GAP       | emit silent samples (PHONEME_GAP_EN only)
// DONE      | one-cycle done pulse, busy low
module phoneme_playback_engine #(
  parameter int SAMPLE_DIV   = 6250,
  parameter int ADDR_W       = 16,
  parameter int NUM_PHONEMES = 64,
  parameter int GAP_TICKS    = 2
) (
  input logic clk,
  input logic rst,
  phoneme_playback_engine_if.slave bus
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);

  if (SAMPLE_DIV < 4 || GAP_TICKS < 0) begin : g_param_check
    $error("phoneme_playback_engine: SAMPLE_DIV must be >= 4 and GAP_TICKS >= 0");
  end

  typedef enum logic [2:0] {
    IDLE,
    IDX_REQ,
    IDX_LOAD,
    FETCH,
    LATCH,
    WAIT_TICK,
`ifdef PHONEME_GAP_EN
    GAP,
`endif
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q;
  logic              tick;
  logic              code_ok_q, code_ok_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [15:0]       rem_q, rem_d;
  logic [7:0]        hold_q, hold_d;
  logic [7:0]        idx_addr_q, idx_addr_d;
  logic [ADDR_W-1:0] smp_addr_q, smp_addr_d;
  logic [7:0]        sample_q, sample_d;
  logic              valid_d;
  logic              busy_d;
  logic              done_d;
  logic              sel_in_range;

`ifdef PHONEME_GAP_EN
  localparam int GAP_W = (GAP_TICKS < 1) ? 1 : $clog2(GAP_TICKS + 1);
  logic [GAP_W-1:0]  gap_q, gap_d;
`endif

  assign tick         = (div_q == DIV_W'(SAMPLE_DIV - 1));
  assign sel_in_range = (int'(bus.phoneme_sel) < NUM_PHONEMES);

  always_comb begin
    state_d    = state_q;
    code_ok_d  = code_ok_q;
    ptr_d      = ptr_q;
    rem_d      = rem_q;
    hold_d     = hold_q;
    idx_addr_d = idx_addr_q;
    smp_addr_d = smp_addr_q;
    sample_d   = sample_q;
    valid_d    = 1'b0;
`ifdef PHONEME_GAP_EN
    gap_d      = gap_q;
`endif
    case (state_q)
      IDLE: begin
        // Index address is registered here so it is already stable during IDX_REQ.
        if (bus.start_phoneme_output) begin
          code_ok_d = sel_in_range;
          state_d   = IDX_REQ;
          if (sel_in_range) idx_addr_d = bus.phoneme_sel;
        end
      end
      IDX_REQ: state_d = code_ok_q ? IDX_LOAD : DONE;
      IDX_LOAD: begin
        ptr_d = ADDR_W'(bus.index_rom_data[31:16]);
        rem_d = bus.index_rom_data[15:0];
        if (bus.index_rom_data[15:0] == 16'd0) begin
          state_d = DONE;
        end else begin
          smp_addr_d = ADDR_W'(bus.index_rom_data[31:16]);
          state_d    = FETCH;
        end
      end
      FETCH: state_d = LATCH;
      LATCH: begin
        hold_d  = bus.sample_rom_data;
        state_d = WAIT_TICK;
      end
      WAIT_TICK: begin
        if (tick) begin
          sample_d = hold_q;
          valid_d  = 1'b1;
          ptr_d    = ptr_q + ADDR_W'(1);
          rem_d    = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
`ifdef PHONEME_GAP_EN
            gap_d   = GAP_W'(GAP_TICKS);
            state_d = (GAP_TICKS == 0) ? DONE : GAP;
`else
            state_d = DONE;
`endif
          end else begin
            smp_addr_d = ptr_q + ADDR_W'(1);
            state_d    = FETCH;
          end
        end
      end
`ifdef PHONEME_GAP_EN
      GAP: begin
        if (tick) begin
          sample_d = 8'h80;
          valid_d  = 1'b1;
          gap_d    = gap_q - GAP_W'(1);
          if (gap_q == GAP_W'(1)) state_d = DONE;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q                 <= IDLE;
      div_q                   <= '0;
      code_ok_q               <= 1'b0;
      ptr_q                   <= '0;
      rem_q                   <= '0;
      hold_q                  <= 8'h80;
      idx_addr_q              <= '0;
      smp_addr_q              <= '0;
      sample_q                <= 8'h80;
      bus.audio_valid         <= 1'b0;
      bus.phoneme_speech_busy <= 1'b0;
      bus.phoneme_done        <= 1'b0;
`ifdef PHONEME_GAP_EN
      gap_q                   <= '0;
`endif
    end else begin
      state_q                 <= state_d;
      div_q                   <= tick ? '0 : div_q + DIV_W'(1);
      code_ok_q               <= code_ok_d;
      ptr_q                   <= ptr_d;
      rem_q                   <= rem_d;
      hold_q                  <= hold_d;
      idx_addr_q              <= idx_addr_d;
      smp_addr_q              <= smp_addr_d;
      sample_q                <= sample_d;
      bus.audio_valid         <= valid_d;
      bus.phoneme_speech_busy <= busy_d;
      bus.phoneme_done        <= done_d;
`ifdef PHONEME_GAP_EN
      gap_q                   <= gap_d;
`endif
    end
  end

  assign bus.index_rom_addr  = idx_addr_q;
  assign bus.sample_rom_addr = smp_addr_q;
  assign bus.audio_sample    = sample_q;

endmodule
